cu_exec_controller: RTL and testbench
=====================================

# cu_exec_controller

Execution-mode controller for the control unit. It sits between the board buttons and switches and the CAR sequencing logic, and decides whether the CAR auto-fetches the next instruction or parks at end-of-instruction. It supports three behaviours: free-running, single-step and PC breakpoint. It debounces the step/run buttons, issues one-cycle next-instruction stimuli, tracks halt, and counts retired instructions.

## Interface
- DB_CYCLES, 1000000 — stable-input cycles required before a button level is accepted (≥2)
- PC_WIDTH, 8 — width of PC and breakpoint address
- CNT_WIDTH, 16 — width of retired-instruction counter
- i_clk  in  1  system clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_btn_step  in  1  raw step button, asynchronous, active-high
- i_btn_run  in  1  raw run/resume button, asynchronous, active-high
- i_sw_step_mode  in  1  raw step-mode switch (1 = single-step), asynchronous
- i_bp_en  in  1  breakpoint enable, synchronous
- i_bp_addr  in  PC_WIDTH  breakpoint address, synchronous
- i_pc  in  PC_WIDTH  current PC (address of next instruction once current one ends)
- i_control_word_car  in  2  CAR sequencing field of current microinstruction; 2'b11 = end-of-instruction
- i_ctrl_halt  in  1  halt bit (C23) of current microinstruction
- o_step_execution  out  1  to CAR step-execution input; 1 = park at end-of-instruction
- o_next_instr_stimulus  out  1  one-cycle pulse releasing a parked CAR
- o_state  out  2  FSM state: 00 RUN, 01 STEP, 10 HALTED, 11 BREAK
- o_bp_hit  out  1  high while in BREAK
- o_instr_count  out  CNT_WIDTH  retired instructions, saturating

## Operation
- Input conditioning: each raw input passes through a 2-FF synchronizer, then a debouncer. The debounce counter resets whenever the synchronized level equals the accepted level. It increments otherwise; on reaching DB_CYCLES-1, the accepted level takes the synchronized value. Press = rising edge of accepted button level (one-cycle pulse). The switch uses its accepted level.
- eoi = (i_control_word_car == 2'b11) && !i_ctrl_halt.
- bp_match = i_bp_en && (i_pc == i_bp_addr) && !bp_skip.
- o_step_execution is combinational: (state != RUN) || bp_match.
- FSM:
  - RUN: on eoi && bp_match → BREAK. Otherwise, if switch = 1 → STEP.
  - STEP: if switch = 0 and no step pending → RUN.
  - BREAK: on run press → RUN if switch = 0, else STEP. On run press, set bp_skip and clear step_pending.
  - Any state: (i_control_word_car == 2'b11) && i_ctrl_halt → HALTED. HALTED is left only by reset.
- bp_skip clears when i_pc != i_bp_addr.
- Step handshake:
  - A step press in STEP or BREAK sets step_pending. A step press in RUN or HALTED is ignored.
  - While step_pending && eoi, drive o_next_instr_stimulus = 1 for exactly one cycle and clear step_pending.
  - A second press while pending is absorbed; it is not queued.
- Counter: increments when eoi && (!o_step_execution || o_next_instr_stimulus). It holds at all-ones.
- Priority within one cycle: halt > breakpoint > run press > switch change > step press. A run press and step press together: run wins and the step is discarded.

## Timing
- Reset values:
  - state = RUN (o_state = 00)
  - o_step_execution = 0 unless bp_match
  - o_next_instr_stimulus = 0, o_bp_hit = 0, o_instr_count = 0
  - step_pending = 0, bp_skip = 0
  - synchronizers, accepted levels and debounce counters = 0
- Button/switch latency: change on raw pin → accepted level after 2 + DB_CYCLES cycles. The press pulse appears in the same cycle the accepted level rises.
- Stimulus: asserted in the first eoi cycle at or after the cycle in which step_pending is set (earliest the cycle after the press pulse). The CAR returns to 0 on the following edge.
- Breakpoint is combinational: the CAR parks on the same eoi cycle the match is detected; the state is BREAK on the next edge.
- Reset mid-debounce or mid-pending clears everything; no stimulus is issued after reset.

## Test plan
- DB_CYCLES=4, switch = 0, program with 5 instructions, no halt → o_step_execution stays 0, o_state = 00, o_instr_count = 5 after 5 eoi cycles.
- Switch = 1; a 10-cycle step press with 2-cycle bounce glitches → exactly one o_next_instr_stimulus pulse at the next eoi, count + 1, CAR parks again.
- i_bp_en = 1, i_bp_addr = 0x04 in RUN → at eoi with i_pc = 0x04: o_step_execution = 1 that cycle, o_state = 11 the next cycle, count not incremented. Run press → RUN, resumes, does not re-break at 0x04.
- HALT microinstruction (word 11, C23 = 1) → o_state = 10; step/run presses ignored; counter frozen; reset returns to 00.
- Step and run pressed in the same cycle during BREAK → RUN, no stimulus pulse.
- Counter preloaded near saturation (CNT_WIDTH = 4): 20 eoi cycles → o_instr_count = 4'hF, no wrap.

Source files
------------

// File: rtl/cu_exec_controller.sv
// Execution-mode controller: free-run, single-step and PC breakpoint
// control for the CAR, with button conditioning and a retire counter.
module cu_exec_controller #(
    parameter int DB_CYCLES = 1000000,
    parameter int PC_WIDTH  = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_btn_step,
    input  logic                 i_btn_run,
    input  logic                 i_sw_step_mode,
    input  logic                 i_bp_en,
    input  logic [PC_WIDTH-1:0]  i_bp_addr,
    input  logic [PC_WIDTH-1:0]  i_pc,
    input  logic [1:0]           i_control_word_car,
    input  logic                 i_ctrl_halt,
    output logic                 o_step_execution,
    output logic                 o_next_instr_stimulus,
    output logic [1:0]           o_state,
    output logic                 o_bp_hit,
    output logic [CNT_WIDTH-1:0] o_instr_count
);

    localparam int DB_W = $clog2(DB_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STEP  = 2'b01,
        ST_HALT  = 2'b10,
        ST_BREAK = 2'b11
    } state_t;

    state_t state_q, state_d;

    logic [2:0] raw;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] acc;
    logic [1:0] acc_d;

    logic step_press;
    logic run_press;
    logic sw_step;
    logic eoi;
    logic halt_req;
    logic bp_match;
    logic stimulus;
    logic step_pending;
    logic bp_skip;
    logic step_ok;
    logic cnt_inc;

    assign raw = {i_sw_step_mode, i_btn_run, i_btn_step};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // accepted level only moves after DB_CYCLES consecutive differing samples
    for (genvar g = 0; g < 3; g++) begin : g_db
        logic [DB_W-1:0] cnt_q;
        logic            lvl_q;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
            end else if (sync2[g] == lvl_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DB_LAST) begin
                cnt_q <= '0;
                lvl_q <= sync2[g];
            end else begin
                cnt_q <= cnt_q + DB_W'(1);
            end
        end

        assign acc[g] = lvl_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_d <= '0;
        end else begin
            acc_d <= acc[1:0];
        end
    end

    assign step_press = acc[0] & ~acc_d[0];
    assign run_press  = acc[1] & ~acc_d[1];
    assign sw_step    = acc[2];

    assign eoi      = (i_control_word_car == 2'b11) && !i_ctrl_halt;
    assign halt_req = (i_control_word_car == 2'b11) && i_ctrl_halt;
    assign bp_match = i_bp_en && (i_pc == i_bp_addr) && !bp_skip;

    assign o_step_execution      = (state_q != ST_RUN) || bp_match;
    assign stimulus              = step_pending && eoi && (state_q != ST_HALT);
    assign o_next_instr_stimulus = stimulus;
    assign o_state               = state_q;
    assign o_bp_hit              = (state_q == ST_BREAK);

    always_comb begin
        state_d = state_q;
        if (halt_req) begin
            state_d = ST_HALT;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (eoi && bp_match) begin
                        state_d = ST_BREAK;
                    end else if (sw_step) begin
                        state_d = ST_STEP;
                    end
                end
                ST_STEP: begin
                    if (!sw_step && !step_pending) begin
                        state_d = ST_RUN;
                    end
                end
                ST_BREAK: begin
                    if (run_press) begin
                        state_d = sw_step ? ST_STEP : ST_RUN;
                    end
                end
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // a step press only arms when it cannot be overridden by a mode change
    assign step_ok = (state_q == ST_STEP || state_q == ST_BREAK)
                  && (state_d == ST_STEP || state_d == ST_BREAK);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            step_pending <= 1'b0;
        end else if (halt_req || state_q == ST_HALT) begin
            step_pending <= 1'b0;
        end else if (state_q == ST_BREAK && run_press) begin
            step_pending <= 1'b0;
        end else if (stimulus) begin
            step_pending <= 1'b0;
        end else if (step_press && !run_press && step_ok) begin
            step_pending <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bp_skip <= 1'b0;
        end else if (state_q == ST_BREAK && run_press && !halt_req) begin
            bp_skip <= 1'b1;
        end else if (i_pc != i_bp_addr) begin
            bp_skip <= 1'b0;
        end
    end

    assign cnt_inc = eoi && (!o_step_execution || stimulus)
                  && (o_instr_count != {CNT_WIDTH{1'b1}});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_instr_count <= '0;
        end else if (cnt_inc) begin
            o_instr_count <= o_instr_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_cu_exec_controller.sv
// Directed bench for cu_exec_controller driven by a small CAR model;
// expected values queue up in a scoreboard and are popped at each check.
module tb_cu_exec_controller;

    localparam int DB = 4;
    localparam int PW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          btn_step = 1'b0;
    logic          btn_run = 1'b0;
    logic          sw = 1'b0;
    logic          bp_en = 1'b0;
    logic [PW-1:0] bp_addr = '0;
    logic [PW-1:0] pc_o = '0;
    logic [1:0]    car = 2'b00;
    logic          halt = 1'b0;
    logic          se;
    logic          stim;
    logic [1:0]    st;
    logic          bp_hit;
    logic [CW-1:0] cnt;

    always #5 clk = ~clk;

    cu_exec_controller #(
        .DB_CYCLES(DB),
        .PC_WIDTH (PW),
        .CNT_WIDTH(CW)
    ) dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_btn_step           (btn_step),
        .i_btn_run            (btn_run),
        .i_sw_step_mode       (sw),
        .i_bp_en              (bp_en),
        .i_bp_addr            (bp_addr),
        .i_pc                 (pc_o),
        .i_control_word_car   (car),
        .i_ctrl_halt          (halt),
        .o_step_execution     (se),
        .o_next_instr_stimulus(stim),
        .o_state              (st),
        .o_bp_hit             (bp_hit),
        .o_instr_count        (cnt)
    );

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mpc = 0;
    int   pcm = 0;
    int   retired = 0;
    int   stim_cnt = 0;
    int   halt_pc = 0;
    int   c0 = 0;
    bit   halt_armed = 1'b0;
    bit   se_seen = 1'b0;
    bit   pat[$] = '{1, 1, 0, 0, 1, 1, 0, 0,
                     1, 1, 1, 1, 1, 1, 1, 1, 1, 1};

    function automatic void expect_v(string tag, int v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endfunction

    task automatic cmp(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $error("FAIL sb_empty observed=%0d", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === 32'(e.val)) else begin
                n_bad++;
                $error("FAIL %s observed=%0d expected=%0d",
                       e.tag, obs, e.val);
            end
        end
    endtask

    task automatic drive();
        car   = (mpc == 1) ? 2'b11 : 2'b00;
        halt  = (mpc == 1) && halt_armed && (pcm == halt_pc);
        pc_o  = PW'(pcm);
    endtask

    // one clock: sample at the falling edge, then step the CAR model
    task automatic adv();
        logic s_se;
        logic s_st;
        #3;
        s_se = se;
        s_st = stim;
        if (s_se) se_seen = 1'b1;
        if (s_st) stim_cnt++;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mpc = 0;
            pcm = 0;
        end else if (mpc == 0) begin
            mpc = 1;
        end else if (!halt && (!s_se || s_st)) begin
            mpc = 0;
            pcm++;
            retired++;
        end
        drive();
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        btn_step = 1'b0;
        btn_run  = 1'b0;
        repeat (3) adv();
        retired  = 0;
        stim_cnt = 0;
        rst_n    = 1'b1;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget,
                              input string tag);
        for (int i = 0; i < budget && st !== s; i++) adv();
        expect_v(tag, int'(s));
        cmp(st);
    endtask

    initial begin
        @(posedge clk);
        #2;
        drive();
        do_reset();

        expect_v("rst_state", 0);  cmp(st);
        expect_v("rst_se", 0);     cmp(se);
        expect_v("rst_stim", 0);   cmp(stim);
        expect_v("rst_bp_hit", 0); cmp(bp_hit);
        expect_v("rst_count", 0);  cmp(cnt);

        // free run: five instructions
        se_seen = 1'b0;
        expect_v("run_count", 5);
        expect_v("run_state", 0);
        expect_v("run_no_park", 0);
        repeat (10) adv();
        cmp(cnt);
        cmp(st);
        cmp(se_seen);

        // single-step with a bouncy step button
        sw = 1'b1;
        wait_state(2'b01, 20, "enter_step");
        repeat (4) adv();
        expect_v("park_se", 1);       cmp(se);
        expect_v("park_car", 3);      cmp(car);
        expect_v("park_cnt", retired); cmp(cnt);
        c0 = retired;
        stim_cnt = 0;
        expect_v("step_pulses", 1);
        expect_v("step_cnt", c0 + 1);
        foreach (pat[i]) begin
            btn_step = pat[i];
            adv();
        end
        btn_step = 1'b0;
        repeat (12) adv();
        cmp(stim_cnt);
        cmp(cnt);
        expect_v("repark_se", 1);  cmp(se);
        expect_v("repark_car", 3); cmp(car);

        // breakpoint at 0x04 while running
        sw      = 1'b0;
        bp_en   = 1'b1;
        bp_addr = 8'h04;
        do_reset();
        for (int i = 0; i < 30 && !(mpc == 1 && pcm == 4); i++) adv();
        expect_v("bp_se", 1);        cmp(se);
        expect_v("bp_state_pre", 0); cmp(st);
        adv();
        expect_v("bp_state", 3); cmp(st);
        expect_v("bp_hit", 1);   cmp(bp_hit);
        expect_v("bp_cnt", 4);   cmp(cnt);
        btn_run = 1'b1;
        repeat (8) adv();
        btn_run = 1'b0;
        wait_state(2'b00, 20, "bp_resume");
        repeat (12) adv();
        expect_v("bp_no_rebreak", 0); cmp(st);
        expect_v("bp_hit_clr", 0);    cmp(bp_hit);
        expect_v("bp_run_cnt", retired); cmp(cnt);

        // step and run pressed together while broken
        bp_addr = 8'h02;
        do_reset();
        wait_state(2'b11, 20, "both_break");
        stim_cnt = 0;
        btn_step = 1'b1;
        btn_run  = 1'b1;
        repeat (8) adv();
        btn_step = 1'b0;
        btn_run  = 1'b0;
        wait_state(2'b00, 20, "both_run");
        repeat (8) adv();
        expect_v("both_no_pulse", 0);  cmp(stim_cnt);
        expect_v("both_cnt", retired); cmp(cnt);

        // halt microinstruction at pc 3
        bp_en      = 1'b0;
        halt_armed = 1'b1;
        halt_pc    = 3;
        do_reset();
        wait_state(2'b10, 20, "halt_enter");
        expect_v("halt_cnt", 3); cmp(cnt);
        stim_cnt = 0;
        btn_step = 1'b1;
        repeat (8) adv();
        btn_step = 1'b0;
        repeat (8) adv();
        btn_run = 1'b1;
        repeat (8) adv();
        btn_run = 1'b0;
        repeat (8) adv();
        sw = 1'b1;
        repeat (10) adv();
        expect_v("halt_hold", 2);     cmp(st);
        expect_v("halt_frozen", 3);   cmp(cnt);
        expect_v("halt_no_pulse", 0); cmp(stim_cnt);
        expect_v("halt_se", 1);       cmp(se);
        sw         = 1'b0;
        halt_armed = 1'b0;
        do_reset();
        expect_v("halt_rst_state", 0); cmp(st);
        expect_v("halt_rst_cnt", 0);   cmp(cnt);

        // counter saturation
        repeat (28) adv();
        expect_v("sat_mid", 14); cmp(cnt);
        repeat (12) adv();
        expect_v("sat_full", 15); cmp(cnt);
        repeat (4) adv();
        expect_v("sat_hold", 15); cmp(cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
